// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer handshake and FIFO write-port bundle for fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    // Producer side: one valid/ready pair and one data word per producer.
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;

    // FIFO write side: the written word carries the owner index above the data.
    logic                  fifo_full;
    logic                  fifo_wen;
    logic [IDW+WIDTH-1:0]  fifo_data;

    // Environment view: producers drive requests, the FIFO drives its full flag.
    modport master (
        output req_valid,
        output req_data,
        output fifo_full,
        input  req_ready,
        input  fifo_wen,
        input  fifo_data
    );

    // Arbiter view.
    modport slave (
        input  req_valid,
        input  req_data,
        input  fifo_full,
        output req_ready,
        output fifo_wen,
        output fifo_data
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among NREQ producers
module fifo_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int BURST = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    fifo_wr_arbiter_if.slave    bus,
    output logic [IDW-1:0]      grant_id,
    output logic                busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDW-1:0]     r_owner;
    logic [IDW-1:0]     w_owner_nxt;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     w_ptr_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;
    logic [IDW-1:0]     r_grant_id;
    logic               r_busy;

    logic [IDW:0]       w_sum;
    logic [IDW-1:0]     w_pick;
    logic               w_any;
    logic               w_owner_valid;
    logic [WIDTH-1:0]   w_owner_data;
    logic               w_xfer;
    logic               w_last;
    logic [IDW-1:0]     w_ptr_inc;

    // Round-robin pick: first valid requester at or after ptr, wrapping modulo NREQ.
    // Walking downward means the smallest offset from ptr is the one left standing.
    always_comb begin
        w_sum  = '0;
        w_pick = '0;
        w_any  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            if (bus.req_valid[IDW'(w_sum)]) begin
                w_pick = IDW'(w_sum);
                w_any  = 1'b1;
            end
        end
    end

    // Select the current owner's valid bit and data word.
    always_comb begin
        w_owner_valid = 1'b0;
        w_owner_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == IDW'(i)) begin
                w_owner_valid = bus.req_valid[i];
                w_owner_data  = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // A beat moves only while granted, the owner offers a word and the FIFO has room.
    assign w_xfer    = (r_state == S_GRANT) && w_owner_valid && !bus.fifo_full;
    assign w_last    = (r_cnt == 4'(BURST - 1));
    assign w_ptr_inc = (r_owner == IDW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

    // State, owner, pointer and beat counter; reset aborts any burst at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= (w_state_nxt == S_GRANT);
            r_grant_id <= (w_state_nxt == S_GRANT) ? w_owner_nxt : '0;
        end
    end

    // Next state: grant on any request, release on burst end or owner dropping valid,
    // and simply hold while the FIFO is full (no timeout).
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_owner_nxt = w_pick;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!w_owner_valid) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = w_ptr_inc;
                    w_cnt_nxt   = '0;
                end else if (w_xfer) begin
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = w_ptr_inc;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Write-port and ready outputs; everything is quiet outside GRANT.
    always_comb begin
        bus.req_ready = '0;
        bus.fifo_wen  = 1'b0;
        bus.fifo_data = '0;
        if (r_state == S_GRANT) begin
            for (int i = 0; i < NREQ; i++) begin
                if (r_owner == IDW'(i)) begin
                    bus.req_ready[i] = !bus.fifo_full;
                end
            end
            bus.fifo_wen  = w_xfer;
            bus.fifo_data = {r_owner, w_owner_data};
        end
    end

    assign grant_id = r_grant_id;
    assign busy     = r_busy;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - table-driven bench with write scoreboard for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int BURST = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [IDW-1:0] grant_id;
    logic           busy;

    fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus_if ();

    fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .BURST(BURST)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if.slave),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] valid;
        logic            full;
        logic            wen;
        logic [NREQ-1:0] ready;
        logic            busy;
        logic [IDW-1:0]  gid;
    } vec_t;

    vec_t                 tbl[$];
    logic [IDW+WIDTH-1:0] sb[$];
    int                   n_vec = 0;
    int                   n_err = 0;
    int                   wcnt[NREQ];
    logic [NREQ-1:0]      acc_mask;

    function automatic logic [WIDTH-1:0] word_of(int i, int n);
        return WIDTH'((i + 1) * 16 + n);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_push(int i, int n);
        sb.push_back({IDW'(i), word_of(i, n)});
    endtask

    task automatic add(logic [NREQ-1:0] v, logic f, logic wen, logic [NREQ-1:0] rdy,
                       logic bsy, logic [IDW-1:0] gid);
        vec_t e;
        e.valid = v; e.full = f; e.wen = wen; e.ready = rdy; e.busy = bsy; e.gid = gid;
        tbl.push_back(e);
    endtask

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) begin
            bus_if.req_data[i*WIDTH +: WIDTH] = word_of(i, wcnt[i]);
        end
    endtask

    // One clock: advance producers that were accepted, drive inputs, then sample at negedge.
    task automatic cycle(logic [NREQ-1:0] v, logic f);
        logic [IDW+WIDTH-1:0] e;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_mask[i]) wcnt[i]++;
        end
        acc_mask = '0;
        bus_if.req_valid = v;
        bus_if.fifo_full = f;
        drive_data();
        @(negedge clk);
        acc_mask = bus_if.req_ready & bus_if.req_valid;
        if (bus_if.fifo_wen) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_write", 32'(bus_if.fifo_wen), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_data", 32'(bus_if.fifo_data), 32'(e));
            end
        end
    endtask

    task automatic run_table(string tag);
        for (int k = 0; k < tbl.size(); k++) begin
            cycle(tbl[k].valid, tbl[k].full);
            check($sformatf("%s[%0d].wen", tag, k), 32'(bus_if.fifo_wen), 32'(tbl[k].wen));
            check($sformatf("%s[%0d].ready", tag, k), 32'(bus_if.req_ready), 32'(tbl[k].ready));
            check($sformatf("%s[%0d].busy", tag, k), 32'(busy), 32'(tbl[k].busy));
            check($sformatf("%s[%0d].gid", tag, k), 32'(grant_id), 32'(tbl[k].gid));
        end
        tbl.delete();
        check({tag, ".sb_left"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic clear_producers();
        for (int i = 0; i < NREQ; i++) wcnt[i] = 0;
        acc_mask = '0;
        bus_if.req_valid = '0;
        bus_if.fifo_full = 1'b0;
        drive_data();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_producers();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic check_quiet(string tag);
        check({tag, ".ready"}, 32'(bus_if.req_ready), 32'd0);
        check({tag, ".wen"}, 32'(bus_if.fifo_wen), 32'd0);
        check({tag, ".data"}, 32'(bus_if.fifo_data), 32'd0);
        check({tag, ".gid"}, 32'(grant_id), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        bus_if.req_valid = NREQ'($urandom);
        bus_if.fifo_full = 1'($urandom);
        bus_if.req_data  = (NREQ*WIDTH)'($urandom);
        acc_mask = '0;
        for (int i = 0; i < NREQ; i++) wcnt[i] = 0;

        // Reset with random inputs: all outputs held at 0.
        repeat (2) @(posedge clk);
        bus_if.req_valid = '1;
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_producers();
        for (int k = 0; k < 10; k++) begin
            cycle('0, 1'b0);
            check($sformatf("post_reset[%0d].busy", k), 32'(busy), 32'd0);
        end

        // Single producer, six words: 4-beat burst, idle cycle, then 2 beats.
        do_reset();
        add(4'b0010, 0, 0, 4'b0000, 0, 0);
        for (int w = 0; w < 4; w++) begin
            add(4'b0010, 0, 1, 4'b0010, 1, 1);
            sb_push(1, w);
        end
        add(4'b0010, 0, 0, 4'b0000, 0, 0);
        for (int w = 4; w < 6; w++) begin
            add(4'b0010, 0, 1, 4'b0010, 1, 1);
            sb_push(1, w);
        end
        add(4'b0000, 0, 0, 4'b0010, 1, 1);
        add(4'b0000, 0, 0, 4'b0000, 0, 0);
        run_table("single");

        // All producers requesting: owners 0,1,2,3,0 with one idle cycle between bursts.
        do_reset();
        for (int b = 0; b < 5; b++) begin
            add(4'b1111, 0, 0, 4'b0000, 0, 0);
            for (int w = 0; w < BURST; w++) begin
                add(4'b1111, 0, 1, NREQ'(1 << (b % NREQ)), 1, IDW'(b % NREQ));
                sb_push(b % NREQ, (b / NREQ) * BURST + w);
            end
        end
        add(4'b0000, 0, 0, 4'b0000, 0, 0);
        run_table("fair");

        // FIFO full for 3 cycles after the 2nd word: hold, then finish the burst.
        do_reset();
        add(4'b0100, 0, 0, 4'b0000, 0, 0);
        add(4'b0100, 0, 1, 4'b0100, 1, 2); sb_push(2, 0);
        add(4'b0100, 0, 1, 4'b0100, 1, 2); sb_push(2, 1);
        add(4'b0100, 1, 0, 4'b0000, 1, 2);
        add(4'b0100, 1, 0, 4'b0000, 1, 2);
        add(4'b0100, 1, 0, 4'b0000, 1, 2);
        add(4'b0100, 0, 1, 4'b0100, 1, 2); sb_push(2, 2);
        add(4'b0100, 0, 1, 4'b0100, 1, 2); sb_push(2, 3);
        add(4'b0000, 0, 0, 4'b0000, 0, 0);
        run_table("bpress");

        // Producer 2 drops after 2 words; ptr becomes 3 so 0 wins over 1, then 1 after 0 drops.
        do_reset();
        add(4'b0100, 0, 0, 4'b0000, 0, 0);
        add(4'b0111, 0, 1, 4'b0100, 1, 2); sb_push(2, 0);
        add(4'b0111, 0, 1, 4'b0100, 1, 2); sb_push(2, 1);
        add(4'b0011, 0, 0, 4'b0100, 1, 2);
        add(4'b0011, 0, 0, 4'b0000, 0, 0);
        add(4'b0011, 0, 1, 4'b0001, 1, 0); sb_push(0, 0);
        add(4'b0010, 0, 0, 4'b0001, 1, 0);
        add(4'b0010, 0, 0, 4'b0000, 0, 0);
        add(4'b0010, 0, 1, 4'b0010, 1, 1); sb_push(1, 0);
        add(4'b0000, 0, 0, 4'b0010, 1, 1);
        add(4'b0000, 0, 0, 4'b0000, 0, 0);
        run_table("drop");

        // Reset during the 2nd word of producer 3, then priority restarts at 0.
        do_reset();
        add(4'b1000, 0, 0, 4'b0000, 0, 0);
        add(4'b1000, 0, 1, 4'b1000, 1, 3); sb_push(3, 0);
        run_table("midrst_a");
        sb_push(3, 1);
        cycle(4'b1000, 1'b0);
        check("midrst.wen_before", 32'(bus_if.fifo_wen), 32'd1);
        check("midrst.sb_left", 32'(sb.size()), 32'd0);
        sb.delete();
        reset_n = 1'b0;
        #1;
        check_quiet("midrst_async");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_producers();
        add(4'b1010, 0, 0, 4'b0000, 0, 0);
        add(4'b1010, 0, 1, 4'b0010, 1, 1); sb_push(1, 0);
        add(4'b0000, 0, 0, 4'b0010, 1, 1);
        add(4'b0000, 0, 0, 4'b0000, 0, 0);
        run_table("midrst_b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
